uart_rx_controller: RTL and testbench

- Sequencing controller for the 8-bit, even-parity UART receive path.
- Synchronises the serial line and detects and validates the start bit.
- Runs a 16x-oversampled mid-bit sampling schedule through data, parity and stop bits.
- Delivers each frame with its error flags to the downstream consumer through a one-entry valid/ready holding register.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_controller.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit controllers: frame geometry,
// oversampling constants, FSM state encoding and parity helper.
package uart_pkg;

   localparam int DATA_BITS  = 8;
   localparam int OVERSAMPLE = 16;
   localparam int MID_TICK   = OVERSAMPLE / 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   typedef enum logic {
      PARITY_EVEN,
      PARITY_ODD
   } parity_mode_t;

   localparam parity_mode_t PARITY_MODE = PARITY_EVEN;

   // High when the ones-count over data plus parity bit violates the parity mode.
   function automatic logic parity_error(input logic [DATA_BITS-1:0] data, input logic p);
      return (^data) ^ p ^ (PARITY_MODE == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every CLK_DIV clocks while enabled,
// with a restart input that realigns the phase to a detected edge.
module uart_baud_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic tick
);

   localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else if (restart || !enable || (cnt_reg == CNT_LAST)) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign tick = enable && !restart && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: synchronises the line, runs the 16x mid-bit sampling
// schedule for 8E1 frames and hands each frame to a one-entry valid/ready register.
module uart_rx_controller
   import uart_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_line,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   input  logic                 overrun_clr,
   output logic                 busy
);

   localparam int               OS_W     = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  MID_LAST = OS_W'(MID_TICK - 1);
   localparam int               IDX_W    = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 sync1_reg, sync2_reg, line_prev_reg;
   rx_state_t            state_reg, state_next;
   logic [OS_W-1:0]      os_reg, os_next;
   logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 perr_reg, perr_next;
   logic [DATA_BITS-1:0] rx_data_reg;
   logic                 rx_valid_reg, parity_err_reg, frame_err_reg, overrun_reg;

   logic line_s, fall, start_edge, tick, deliver, hold_free, load, drop;

   assign line_s     = sync2_reg;
   assign fall       = line_prev_reg && !line_s;
   assign start_edge = (state_reg == IDLE) && fall;

   uart_baud_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_baud_tick (
      .clk     (clk),
      .reset   (reset),
      .enable  (state_reg != IDLE),
      .restart (start_edge),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_reg     <= 1'b1;
         sync2_reg     <= 1'b1;
         line_prev_reg <= 1'b1;
         state_reg     <= IDLE;
         os_reg        <= '0;
         bit_idx_reg   <= '0;
         shift_reg     <= '0;
         perr_reg      <= 1'b0;
      end else begin
         sync1_reg     <= rx_line;
         sync2_reg     <= sync1_reg;
         line_prev_reg <= sync2_reg;
         state_reg     <= state_next;
         os_reg        <= os_next;
         bit_idx_reg   <= bit_idx_next;
         shift_reg     <= shift_next;
         perr_reg      <= perr_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      os_next      = os_reg;
      bit_idx_next = bit_idx_reg;
      shift_next   = shift_reg;
      perr_next    = perr_reg;
      deliver      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (fall) begin
               state_next = START;
               os_next    = '0;
            end
         end
         START: begin
            if (tick) begin
               if (os_reg == MID_LAST) begin
                  // A line back high at mid start bit was a glitch, not a frame.
                  state_next   = line_s ? IDLE : DATA;
                  os_next      = '0;
                  bit_idx_next = '0;
               end else begin
                  os_next = os_reg + OS_W'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (os_reg == OS_LAST) begin
                  os_next                 = '0;
                  shift_next[bit_idx_reg] = line_s;
                  bit_idx_next            = bit_idx_reg + IDX_W'(1);
                  if (bit_idx_reg == IDX_LAST) begin
                     state_next = PARITY;
                  end
               end else begin
                  os_next = os_reg + OS_W'(1);
               end
            end
         end
         PARITY: begin
            if (tick) begin
               if (os_reg == OS_LAST) begin
                  os_next    = '0;
                  perr_next  = parity_error(shift_reg, line_s);
                  state_next = STOP;
               end else begin
                  os_next = os_reg + OS_W'(1);
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (os_reg == OS_LAST) begin
                  os_next    = '0;
                  deliver    = 1'b1;
                  state_next = IDLE;
               end else begin
                  os_next = os_reg + OS_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // An accept in the delivery cycle frees the slot for the new frame.
   assign hold_free = !rx_valid_reg || rx_ready;
   assign load      = deliver && hold_free;
   assign drop      = deliver && !hold_free;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_data_reg    <= '0;
         rx_valid_reg   <= 1'b0;
         parity_err_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         if (load) begin
            rx_data_reg    <= shift_reg;
            parity_err_reg <= perr_reg;
            frame_err_reg  <= !line_s;
            rx_valid_reg   <= 1'b1;
         end else if (rx_valid_reg && rx_ready) begin
            rx_valid_reg <= 1'b0;
         end
         if (drop) begin
            overrun_reg <= 1'b1;
         end else if (overrun_clr) begin
            overrun_reg <= 1'b0;
         end
      end
   end

   assign rx_data    = rx_data_reg;
   assign rx_valid   = rx_valid_reg;
   assign parity_err = parity_err_reg;
   assign frame_err  = frame_err_reg;
   assign overrun    = overrun_reg;
   assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Scoreboard bench for uart_rx_controller: frames are serialised onto rx_line and
// expected deliveries are queued, then matched against each valid/ready transfer.
module tb_uart_rx_controller;

   localparam int CLK_DIV   = 4;
   localparam int BIT_CLKS  = 16 * CLK_DIV;
   // Clocks from START entry to the stop-bit sampling cycle.
   localparam int STOP_OFFS = CLK_DIV * (8 + 16 * 10) - 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_line = 1'b1;
   logic       rx_ready = 1'b1;
   logic       overrun_clr = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, parity_err, frame_err, overrun, busy;

   int checks = 0;
   int failures = 0;
   int valid_cycles = 0;
   logic [9:0] exp_q[$];

   uart_rx_controller #(
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_line     (rx_line),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .overrun_clr (overrun_clr),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick_clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic b);
      rx_line = b;
      tick_clks(BIT_CLKS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input logic expect_load);
      if (expect_load) exp_q.push_back({~stop, p ^ (^d), d});
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(p);
      drive_bit(stop);
      rx_line = 1'b1;
      tick_clks(BIT_CLKS / 2);
      $display("sent data=%02h parity=%0d stop=%0d expect_load=%0d", d, p, stop, expect_load);
   endtask

   // Transfer monitor: sampled on the falling edge, away from DUT updates.
   initial begin
      logic [9:0] e;
      forever begin
         @(negedge clk);
         if (reset && rx_valid) valid_cycles++;
         if (reset && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_frame", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check_eq("rx_data", rx_data, e[7:0]);
               check_eq("parity_err", parity_err, e[8]);
               check_eq("frame_err", frame_err, e[9]);
               $display("frame data=%02h perr=%0d ferr=%0d", rx_data, parity_err, frame_err);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      int busy_cnt;
      int n;

      tick_clks(3);
      check_eq("rst_rx_data", rx_data, 8'h00);
      check_eq("rst_rx_valid", rx_valid, 0);
      check_eq("rst_flags", {parity_err, frame_err, overrun}, 3'b000);
      check_eq("rst_busy", busy, 0);
      reset = 1'b1;
      tick_clks(5);

      // Clean frame with consumer always ready.
      rx_ready = 1'b1;
      v0 = valid_cycles;
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      check_eq("clean_valid_pulse_len", valid_cycles - v0, 1);
      check_eq("clean_busy_idle", busy, 0);
      check_eq("clean_queue_empty", exp_q.size(), 0);

      // Parity error, then a correct odd-weight byte.
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
      send_frame(8'h01, 1'b1, 1'b1, 1'b1);

      // Framing error, then recovery.
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      send_frame(8'h55, 1'b0, 1'b1, 1'b1);
      check_eq("err_queue_empty", exp_q.size(), 0);

      // Start-bit glitch.
      v0 = valid_cycles;
      busy_cnt = 0;
      rx_line = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (i == 12) rx_line = 1'b1;
         tick_clks(1);
         if (busy) busy_cnt++;
      end
      check_eq("glitch_busy_len_ok", (busy_cnt >= 30 && busy_cnt <= 34), 1);
      check_eq("glitch_no_valid", valid_cycles - v0, 0);
      check_eq("glitch_busy_idle", busy, 0);

      // Overrun: second frame dropped while first is held.
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0);
      check_eq("ovr_valid_held", rx_valid, 1);
      check_eq("ovr_data_held", rx_data, 8'h11);
      check_eq("ovr_set", overrun, 1);
      rx_ready = 1'b1;
      tick_clks(2);
      check_eq("ovr_accepted", rx_valid, 0);
      check_eq("ovr_sticky", overrun, 1);
      overrun_clr = 1'b1;
      tick_clks(1);
      overrun_clr = 1'b0;
      check_eq("ovr_cleared", overrun, 0);
      check_eq("ovr_queue_empty", exp_q.size(), 0);

      // Accept of the held frame in the same cycle the next frame loads.
      rx_ready = 1'b0;
      send_frame(8'h33, 1'b0, 1'b1, 1'b1);
      fork
         send_frame(8'h44, 1'b0, 1'b1, 1'b1);
         begin
            n = 0;
            do begin
               tick_clks(1);
               n++;
            end while (!busy && n < 200);
            check_eq("sim_busy_seen", busy, 1);
            repeat (STOP_OFFS) @(posedge clk);
            #1;
            rx_ready = 1'b1;
            tick_clks(1);
            rx_ready = 1'b0;
         end
      join
      check_eq("sim_valid", rx_valid, 1);
      check_eq("sim_data", rx_data, 8'h44);
      check_eq("sim_no_overrun", overrun, 0);
      rx_ready = 1'b1;
      tick_clks(2);
      check_eq("sim_queue_empty", exp_q.size(), 0);

      // Reset in the middle of data bit 4 of 0xFF.
      rx_line = 1'b0;
      tick_clks(BIT_CLKS);
      rx_line = 1'b1;
      tick_clks(BIT_CLKS * 4 + 20);
      check_eq("mid_busy", busy, 1);
      reset = 1'b0;
      #1;
      check_eq("mid_rst_data", rx_data, 8'h00);
      check_eq("mid_rst_valid", rx_valid, 0);
      check_eq("mid_rst_flags", {parity_err, frame_err, overrun}, 3'b000);
      check_eq("mid_rst_busy", busy, 0);
      tick_clks(3);
      reset = 1'b1;
      tick_clks(BIT_CLKS);
      send_frame(8'h80, 1'b1, 1'b1, 1'b1);
      check_eq("final_queue_empty", exp_q.size(), 0);
      check_eq("final_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
